// File: rtl/buzzer_tone_seq.sv
// Single-note PWM tone sequencer: latches a note request, derives the tone period
// with a serial divider, then plays a PWM tone for a whole number of milliseconds.
module buzzer_tone_seq #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int          FREQ_W = 20,
  parameter int          DUR_W  = 16,
  parameter int unsigned GAP_MS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [FREQ_W-1:0] freq,
  input  logic [7:0]        duty,
  input  logic [DUR_W-1:0]  dur_ms,
  output logic              busy,
  output logic              done,
  output logic              buzzer_out
);

  localparam logic [31:0] MS_CYC   = 32'(CLK_HZ / 1000);
  localparam logic [31:0] DIVIDEND = 32'(CLK_HZ);
  localparam logic [63:0] GAP_CYC  = 64'(GAP_MS) * 64'(CLK_HZ / 1000);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYC - 64'd1);

  typedef enum logic [1:0] {IDLE, CALC, PLAY, GAP} state_t;

  state_t             state, next_state;
  logic [FREQ_W-1:0]  freq_r;
  logic [7:0]         duty_r;
  logic [DUR_W-1:0]   dur_r;
  logic [31:0]        rem, quo, period, high_time, phase, pre_cnt, gap_cnt;
  logic [4:0]         bit_idx;
  logic [DUR_W-1:0]   ms_cnt;

  logic [32:0] rem_shift;
  logic [31:0] divisor, rem_next, quo_next, period_calc, high_calc;
  logic [39:0] prod;
  logic        fits, calc_last, ms_tick, play_end, gap_end;

  // One restoring-divider step per CALC cycle, MSB of the dividend first.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    divisor     = 32'(freq_r);
    rem_shift   = {rem, DIVIDEND[5'd31 - bit_idx]};
    fits        = (rem_shift >= {1'b0, divisor});
    rem_next    = fits ? 32'(rem_shift - {1'b0, divisor}) : rem_shift[31:0];
    quo_next    = {quo[30:0], fits};
    period_calc = (quo_next < 32'd2) ? 32'd2 : quo_next;
    prod        = 40'(period_calc) * 40'(duty_r);
    high_calc   = 32'(prod >> 8);
    calc_last   = (bit_idx == 5'd31);
    ms_tick     = (pre_cnt == MS_CYC - 32'd1);
    play_end    = (dur_r == '0) || (ms_tick && (ms_cnt == dur_r - DUR_W'(1)));
    gap_end     = (gap_cnt == GAP_LAST);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start && !stop) next_state = (freq != '0) ? CALC : PLAY;
      CALC: if (stop) next_state = IDLE;
            else if (calc_last) next_state = PLAY;
      PLAY: if (stop) next_state = IDLE;
            else if (play_end) next_state = (GAP_MS == 0) ? IDLE : GAP;
      GAP:  if (stop || gap_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      done       <= 1'b0;
      buzzer_out <= 1'b0;
      freq_r     <= '0;
      duty_r     <= '0;
      dur_r      <= '0;
      rem        <= '0;
      quo        <= '0;
      bit_idx    <= '0;
      period     <= '0;
      high_time  <= '0;
      phase      <= '0;
      pre_cnt    <= '0;
      ms_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state      <= next_state;
      done       <= (state == PLAY) && play_end && !stop;
      buzzer_out <= (state == PLAY) && !stop && (freq_r != '0) && (phase < high_time);
      case (state)
        IDLE: begin
          if (start && !stop) begin
            freq_r <= freq;
            duty_r <= duty;
            dur_r  <= dur_ms;
          end
          rem     <= '0;
          quo     <= '0;
          bit_idx <= '0;
          phase   <= '0;
          pre_cnt <= '0;
          ms_cnt  <= '0;
          gap_cnt <= '0;
        end
        CALC: begin
          rem     <= rem_next;
          quo     <= quo_next;
          bit_idx <= bit_idx + 5'd1;
          if (calc_last) begin
            period    <= period_calc;
            high_time <= high_calc;
          end
        end
        PLAY: begin
          phase   <= (phase == period - 32'd1) ? '0 : phase + 32'd1;
          pre_cnt <= ms_tick ? '0 : pre_cnt + 32'd1;
          if (ms_tick) ms_cnt <= ms_cnt + DUR_W'(1);
        end
        GAP: gap_cnt <= gap_cnt + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_buzzer_tone_seq.sv
// Scoreboard bench for buzzer_tone_seq at CLK_HZ=100_000 (100 cycles per ms); a second
// instance with a 1 ms gap covers the GAP state.
`timescale 1ns/1ps
module tb_buzzer_tone_seq;

  localparam int unsigned CLK_HZ = 100_000;
  localparam int          FREQ_W = 26;
  localparam int          DUR_W  = 16;

  logic              clk = 1'b0, reset = 1'b1;
  logic              start = 1'b0, stop = 1'b0, start_g = 1'b0;
  logic [FREQ_W-1:0] freq = '0;
  logic [7:0]        duty = '0;
  logic [DUR_W-1:0]  dur_ms = '0;
  logic              busy, done, buzzer_out;
  logic              busy_g, done_g, buzz_g;

  always #5 clk = ~clk;

  buzzer_tone_seq #(.CLK_HZ(CLK_HZ), .FREQ_W(FREQ_W), .DUR_W(DUR_W), .GAP_MS(0)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .freq(freq), .duty(duty),
    .dur_ms(dur_ms), .busy(busy), .done(done), .buzzer_out(buzzer_out));

  buzzer_tone_seq #(.CLK_HZ(CLK_HZ), .FREQ_W(FREQ_W), .DUR_W(DUR_W), .GAP_MS(1)) dut_gap (
    .clk(clk), .reset(reset), .start(start_g), .stop(stop), .freq(freq), .duty(duty),
    .dur_ms(dur_ms), .busy(busy_g), .done(done_g), .buzzer_out(buzz_g));

  // Expected per-note profile; -1 marks a field that is not compared.
  typedef struct {
    string name;
    int    busy_cyc;
    int    highs;
    int    rises;
    int    dones;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: measures each busy window and compares it against the queued expectation.
  bit   in_note = 1'b0, post = 1'b0, prev = 1'b0;
  int   b_cnt, h_cnt, r_cnt, d_cnt;
  exp_t e;

  always @(negedge clk) begin
    if (!reset) begin
      if (post) begin
        check("buzz_after_end", buzzer_out, 0);
        post = 1'b0;
      end
      if (busy && !in_note) begin
        in_note = 1'b1;
        b_cnt = 0; h_cnt = 0; r_cnt = 0; d_cnt = 0;
      end
      if (in_note) begin
        if (done) d_cnt++;
        if (busy) begin
          b_cnt++;
          if (buzzer_out) h_cnt++;
          if (buzzer_out && !prev) r_cnt++;
        end else begin
          in_note = 1'b0;
          post    = 1'b1;
          check("note_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.busy_cyc >= 0) check({e.name, "_busy"},  b_cnt, e.busy_cyc);
            if (e.highs >= 0)    check({e.name, "_highs"}, h_cnt, e.highs);
            if (e.rises >= 0)    check({e.name, "_rises"}, r_cnt, e.rises);
            check({e.name, "_done"}, d_cnt, e.dones);
          end
        end
      end else if (done) begin
        check("stray_done", done, 0);
      end
      prev = buzzer_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input int b, input int h, input int r, input int d);
    exp_t x;
    x.name = name; x.busy_cyc = b; x.highs = h; x.rises = r; x.dones = d;
    exp_q.push_back(x);
  endtask

  task automatic send(input logic [FREQ_W-1:0] f, input logic [7:0] d, input logic [DUR_W-1:0] t);
    freq = f; duty = d; dur_ms = t; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    check({name, "_finished"}, busy, 0);
    tick();
  endtask

  task automatic reset_pulse(input string name);
    #2 reset = 1'b1;
    #1;
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_buzz"}, buzzer_out, 0);
    tick();
    tick();
    #3 reset = 1'b0;
    tick();
  endtask

  initial begin
    int gb, gh, gd, gdone_at;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_buzz", buzzer_out, 0);
    check("reset_gap_busy", busy_g, 0);
    reset = 1'b0;
    tick();

    // 1 kHz, 50% duty, 2 ms: period 100, high 50, 32 CALC + 200 PLAY cycles.
    push("tone1k", 232, 100, 2, 1);
    send(26'd1000, 8'd128, 16'd2);
    wait_idle("tone1k", 400);

    // Rest: no CALC, silent for 100 cycles.
    push("rest", 100, 0, 0, 1);
    send(26'd0, 8'd128, 16'd1);
    wait_idle("rest", 200);

    // 2 kHz, duty 64: period 50, high 12; a second start mid-PLAY is ignored.
    push("ignore2nd", 132, 24, 2, 1);
    send(26'd2000, 8'd64, 16'd1);
    repeat (60) tick();
    freq = 26'd5000; duty = 8'd200; dur_ms = 16'd7; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("ignore2nd", 300);

    // Stop on PLAY cycle 500, then an immediate rest note on the first IDLE cycle.
    push("stop", 533, 250, 5, 0);
    send(26'd1000, 8'd128, 16'd10);
    repeat (532) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_idle_next_edge", busy, 0);
    push("restart", 100, 0, 0, 1);
    send(26'd0, 8'd128, 16'd1);
    wait_idle("restart", 200);

    // Period clamps to 2, high_time 1: output toggles every cycle.
    push("clamp", 132, 50, 50, 1);
    send(26'd60_000_000, 8'd128, 16'd1);
    wait_idle("clamp", 300);

    // dur_ms=0: one PLAY cycle, still a done pulse.
    push("dur0", 33, 0, 0, 1);
    send(26'd1000, 8'd128, 16'd0);
    wait_idle("dur0", 100);

    push("duty0", 132, 0, 0, 1);
    send(26'd1000, 8'd0, 16'd1);
    wait_idle("duty0", 300);

    // duty 255: high_time = (100*255)>>8 = 99.
    push("duty255", 132, 99, 1, 1);
    send(26'd1000, 8'd255, 16'd1);
    wait_idle("duty255", 300);

    // start and stop together in IDLE: stop wins.
    freq = 26'd1000; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", busy, 0);
    tick();

    push("rst_calc", -1, -1, -1, 0);
    send(26'd1000, 8'd128, 16'd2);
    repeat (10) tick();
    reset_pulse("rst_calc");

    push("rst_play", -1, -1, -1, 0);
    send(26'd1000, 8'd128, 16'd2);
    repeat (52) tick();
    check("pre_reset_buzz", buzzer_out, 1);
    reset_pulse("rst_play");

    push("replay", 232, 100, 2, 1);
    send(26'd1000, 8'd128, 16'd2);
    wait_idle("replay", 400);

    // GAP instance: 32 CALC + 100 PLAY + 100 GAP cycles, done on the first GAP cycle.
    freq = 26'd1000; duty = 8'd128; dur_ms = 16'd1; start_g = 1'b1;
    tick();
    start_g = 1'b0;
    gb = 0; gh = 0; gd = 0; gdone_at = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy_g) break;
      gb++;
      if (buzz_g) gh++;
      if (done_g) begin
        gd++;
        gdone_at = gb;
      end
    end
    check("gap_busy", gb, 232);
    check("gap_highs", gh, 50);
    check("gap_done_count", gd, 1);
    check("gap_done_at", gdone_at, 133);
    check("gap_no_done_at_end", done_g, 0);

    tick();
    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
